// File: rtl/ahb_slave_mem_if.sv
// Slave-side AHB bus bundle for ahb_slave_mem. The master modport is the
// driving side (arbiter or bench); the slave modport is the memory responder.
interface ahb_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  s_hsel;
    logic [ADDR_WIDTH-1:0] s_haddr;
    logic [1:0]            s_htrans;
    logic                  s_hwrite;
    logic [2:0]            s_hsize;
    logic [2:0]            s_hburst;
    logic                  s_hmastlock;
    logic [DATA_WIDTH-1:0] s_hwdata;
    logic                  s_hready_in;
    logic                  s_hreadyout;
    logic [1:0]            s_hresp;
    logic [DATA_WIDTH-1:0] s_hrdata;

    modport slave (
        input  s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst,
               s_hmastlock, s_hwdata, s_hready_in,
        output s_hreadyout, s_hresp, s_hrdata
    );

    modport master (
        output s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst,
               s_hmastlock, s_hwdata, s_hready_in,
        input  s_hreadyout, s_hresp, s_hrdata
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB slave memory: decodes the address phase, inserts WAIT_STATES wait cycles,
// performs byte-lane writes/reads and answers bad accesses with a 2-cycle ERROR.
module ahb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input logic            hclk,
    input logic            hreset,
    ahb_slave_mem_if.slave bus
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(NBYTES);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WS       = 4'(WAIT_STATES);
    localparam bit         HAS_WAIT = (WAIT_STATES != 0);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [2:0]         size_q, size_d;
    logic               write_q, write_d;

    logic                  accept;
    logic                  open_slot;
    logic                  size_ok;
    logic                  aligned;
    logic                  in_range;
    logic                  legal;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic                  hreadyout;
    logic [1:0]            hresp;
    logic                  mem_we;
    logic [4:0]            lane_end;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_bits;

    // Burst type, lock and the SEQ/NONSEQ distinction do not change how a beat is served.
    assign unused_bits = ^{bus.s_hburst, bus.s_hmastlock, bus.s_htrans[0]};

    assign accept    = bus.s_hsel & bus.s_hready_in & bus.s_htrans[1];
    assign open_slot = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);

    always_comb begin
        size_ok    = (bus.s_hsize <= 3'(OFF_W));
        align_mask = ~({ADDR_WIDTH{1'b1}} << bus.s_hsize);
        aligned    = ((bus.s_haddr & align_mask) == '0);
        in_range   = ((bus.s_haddr >> OFF_W) < ADDR_WIDTH'(MEM_DEPTH));
        legal      = size_ok & aligned & in_range;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        off_d     = off_q;
        size_d    = size_q;
        write_d   = write_q;
        hreadyout = 1'b1;
        hresp     = RESP_OKAY;

        case (state_q)
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (cnt_q == WS) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = RESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                hresp = RESP_ERROR;
            end
            default: begin
            end
        endcase

        // A new address phase can only land in a cycle where this slave is ready.
        if (open_slot) begin
            if (accept) begin
                idx_d   = bus.s_haddr[OFF_W +: IDX_W];
                off_d   = bus.s_haddr[OFF_W-1:0];
                size_d  = bus.s_hsize;
                write_d = bus.s_hwrite;
                if (!legal) begin
                    state_d = ST_ERR1;
                end else if (HAS_WAIT) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = ST_DATA;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge hclk or negedge hreset) begin
        if (!hreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    // Only legal accesses reach DATA, so size_q here never exceeds the bus width.
    assign mem_we   = (state_q == ST_DATA) && write_q;
    assign lane_end = 5'(off_q) + (5'd1 << size_q);

    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
        logic [7:0] mem_lane [MEM_DEPTH];
        logic       lane_we;

        assign lane_we = mem_we && (5'(gi) >= 5'(off_q)) && (5'(gi) < lane_end);

        always_ff @(posedge hclk) begin
            if (hreset && lane_we) begin
                mem_lane[idx_q] <= bus.s_hwdata[8*gi +: 8];
            end
        end

        assign rd_word[8*gi +: 8] = mem_lane[idx_q];
    end

    // The write of a preceding beat commits on the edge that starts this read's
    // DATA cycle, so reading the array directly already sees it.
    assign bus.s_hreadyout = hreadyout;
    assign bus.s_hresp     = hresp;
    assign bus.s_hrdata    = ((state_q == ST_DATA) && !write_q) ? rd_word : '0;
endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB slave-side responder: a word-addressed memory that completes transfers the arbiter forwards on the shared slave bus. It decodes the address phase, inserts a fixed number of wait states, and performs byte-lane writes and reads. It signals a two-cycle ERROR for out-of-range, misaligned or oversize accesses. It is the bus partner of the arbiter's slave-side outputs and serves as the slave model in the arbiter test harness.

Parameters:
ADDR_WIDTH, 32, width of s_haddr
DATA_WIDTH, 32, data bus width; legal values 32 or 64
MEM_DEPTH, 256, number of DATA_WIDTH words; valid byte range 0 .. MEM_DEPTH*DATA_WIDTH/8-1
WAIT_STATES, 0, wait cycles (s_hreadyout=0) per OKAY data phase; legal range 0..15

Ports:
hclk  in  1  bus clock, rising edge
hreset  in  1  asynchronous active-low reset
s_hsel  in  1  slave select
s_haddr  in  ADDR_WIDTH  byte address (address phase)
s_htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
s_hwrite  in  1  1=write
s_hsize  in  3  bytes = 2**s_hsize
s_hburst  in  3  burst type; not used for decode
s_hmastlock  in  1  locked transfer; no behavioural effect
s_hwdata  in  DATA_WIDTH  write data (data phase)
s_hready_in  in  1  bus-level HREADY; qualifies the address phase
s_hreadyout  out  1  slave ready
s_hresp  out  2  OKAY=0, ERROR=1; RETRY and SPLIT are never driven
s_hrdata  out  DATA_WIDTH  read data

Behaviour:
- Reset (hreset=0, asynchronous) drives s_hreadyout=1, s_hresp=OKAY and s_hrdata=0, and sets the FSM to IDLE with the wait counter at 0. Memory contents are not reset. Reset asserted mid-transfer aborts the transfer: no write is committed.
- Address phase accepted on a rising edge with s_hsel & s_hready_in & s_htrans[1]. On acceptance the block latches addr, write, size and the legality result.
- IDLE or BUSY with s_hsel=1 & s_hready_in=1 gives a zero-wait OKAY data phase with no access.
- Legality: an access is illegal if 2**s_hsize > DATA_WIDTH/8, the address is not aligned to 2**s_hsize, or the word index s_haddr/(DATA_WIDTH/8) >= MEM_DEPTH.
- FSM states:
  - IDLE: s_hreadyout=1, s_hresp=OKAY.
  - IDLE -> WAIT on a legal accept with WAIT_STATES>0.
  - IDLE -> DATA on a legal accept with WAIT_STATES=0.
  - IDLE -> ERR1 on an illegal accept.
  - WAIT: s_hreadyout=0, s_hresp=OKAY. The counter counts 1..WAIT_STATES, then -> DATA.
  - DATA: s_hreadyout=1, s_hresp=OKAY. A new accept in the same cycle re-enters WAIT, DATA or ERR1 as above (pipelined back-to-back); otherwise -> IDLE.
  - ERR1: s_hreadyout=0, s_hresp=ERROR. Always -> ERR2.
  - ERR2: s_hreadyout=1, s_hresp=ERROR. A new accept is honoured exactly as in DATA; otherwise -> IDLE.
- Write commit: on the rising edge that ends the DATA cycle, lanes byte_offset .. byte_offset+2**size-1 of the latched word are written from the same lanes of s_hwdata (little-endian). byte_offset = latched addr mod (DATA_WIDTH/8). Other lanes are unchanged. Illegal writes never modify memory.
- Read data: in DATA of a read, s_hrdata = the full memory word at the latched word index, all lanes. In every other cycle s_hrdata=0.
- Read-after-write: the write commits at the edge ending its DATA cycle. A following read to the same address therefore returns the new data, with no forwarding path needed.
- Latency: an OKAY transfer takes WAIT_STATES+1 data-phase cycles. An ERROR transfer takes exactly 2.
- s_hwdata is sampled only in the DATA cycle. Its value during WAIT is ignored.

Test Plan:
- Reset: hreset=0 with the bus idle -> s_hreadyout=1, s_hresp=0, s_hrdata=0. Release on a hclk edge -> outputs unchanged, FSM in IDLE.
- WAIT_STATES=0: NONSEQ write 0xDEADBEEF to addr 0x10, size=2, then NONSEQ read of 0x10 in the next address phase -> each data phase one cycle with s_hreadyout=1; read returns 0xDEADBEEF.
- WAIT_STATES=2: back-to-back write of 0x11223344 to 0x20, then read of 0x20 -> each data phase has exactly 2 cycles of s_hreadyout=0 then 1; read data 0x11223344.
- Byte lanes: word 0x20 holds 0x11223344; byte write 0xAA to 0x21 (size=0, s_hwdata=0x0000AA00) -> read of 0x20 returns 0x1122AA44.
- Errors:
  - Read at byte addr MEM_DEPTH*4 (1024) -> ERR1 then ERR2: s_hresp=1 both cycles, s_hreadyout 0 then 1.
  - Write size=2 to 0x22 (misaligned) -> same two-cycle ERROR; memory unchanged.
- IDLE/BUSY and mid-transfer reset:
  - s_htrans=IDLE/BUSY with s_hsel=1 -> OKAY, zero wait, no memory change.
  - hreset asserted during WAIT of a write to 0x30 -> after reset release, read of 0x30 returns the pre-write value.
